// File: rtl/par2ser_com.sv
`default_nettype none
// ============================================================================
// Module   : par2ser_com
// Brief    : Byte-to-serial converter with K28.5 COM initialization and fill.
// Revision : 1.0
// ============================================================================
module par2ser_com #(
  parameter logic [7:0] COM      = 8'hBC,
  parameter int         INIT_COM = 4
) (
  input  logic       clk32f,
  input  logic       reset,
  input  logic [7:0] in,
  input  logic       validin,
  output logic       out,
  output logic       load,
  output logic       active
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [3:0] c_LAST_COM = 4'(INIT_COM - 1);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [3:0] com_cnt_q, com_cnt_d;
  logic       w_byte_end;

  assign w_byte_end = (cnt_q == 3'd7);

  always_ff @(posedge clk32f) begin
    if (reset) begin
      state_q   <= ST_INIT;
      cnt_q     <= 3'd0;
      shreg_q   <= 8'h00;
      com_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      com_cnt_q <= com_cnt_d;
    end
  end

  // Byte boundary reloads the shifter so consecutive bytes abut with no gap.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 3'd1;
    shreg_d   = {shreg_q[6:0], 1'b0};
    com_cnt_d = com_cnt_q;
    if (w_byte_end) begin
      case (state_q)
        ST_INIT: begin
          shreg_d   = COM;
          com_cnt_d = com_cnt_q + 4'd1;
          if (com_cnt_q == c_LAST_COM) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          shreg_d = validin ? in : COM;
        end
        default: begin
          state_d = ST_INIT;
        end
      endcase
    end
  end

  assign out    = shreg_q[7];
  assign load   = w_byte_end && (state_q == ST_RUN);
  assign active = (state_q == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_par2ser_com.sv
`default_nettype none
// ============================================================================
// Module   : tb_par2ser_com
// Brief    : Directed self-checking bench for par2ser_com.
// Revision : 1.0
// ============================================================================
module tb_par2ser_com;

  logic       clk32f;
  logic       reset;
  logic [7:0] in;
  logic       validin;
  logic       out;
  logic       load;
  logic       active;

  int errors = 0;
  int checks = 0;

  localparam logic [7:0] c_COM = 8'hBC;

  par2ser_com dut (
    .clk32f  (clk32f),
    .reset   (reset),
    .in      (in),
    .validin (validin),
    .out     (out),
    .load    (load),
    .active  (active)
  );

  initial clk32f = 1'b0;
  always #5 clk32f = ~clk32f;

  // Advance one cycle; observation happens mid-cycle on the falling edge.
  task automatic tick();
    @(posedge clk32f);
    @(negedge clk32f);
  endtask

  // Holds reset for n edges; returns positioned in cycle 0 after release.
  task automatic apply_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  // Checks cycles 0..39 of the init sequence, presenting byte b/v at cycle 39.
  task automatic run_init(input string tag, input logic [7:0] b, input logic v);
    logic [7:0] com;
    com = c_COM;
    for (int c = 0; c < 40; c++) begin
      logic exp_out;
      exp_out = (c < 8) ? 1'b0 : com[7 - (c % 8)];
      checks++;
      if (out !== exp_out) begin
        errors++;
        $display("FAIL %s out cycle %0d: got %b want %b", tag, c, out, exp_out);
      end
      checks++;
      if (load !== (c == 39)) begin
        errors++;
        $display("FAIL %s load cycle %0d: got %b want %b", tag, c, load, (c == 39));
      end
      checks++;
      if (active !== (c >= 32)) begin
        errors++;
        $display("FAIL %s active cycle %0d: got %b want %b", tag, c, active, (c >= 32));
      end
      if (c == 39) begin
        in      = b;
        validin = v;
      end
      tick();
    end
  endtask

  // Checks one serialized byte; offers nb/nv at its final (load) cycle and
  // drives junk on the other cycles, which must be ignored.
  task automatic expect_byte(input string tag, input logic [7:0] b,
                             input logic [7:0] nb, input logic nv);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out !== b[7 - i]) begin
        errors++;
        $display("FAIL %s out bit%0d: got %b want %b", tag, 7 - i, out, b[7 - i]);
      end
      checks++;
      if (load !== (i == 7)) begin
        errors++;
        $display("FAIL %s load slot %0d: got %b want %b", tag, i, load, (i == 7));
      end
      checks++;
      if (active !== 1'b1) begin
        errors++;
        $display("FAIL %s active slot %0d: got %b want 1", tag, i, active);
      end
      if (i == 7) begin
        in      = nb;
        validin = nv;
      end else begin
        in      = 8'(i * 37 + 11);
        validin = i[0];
      end
      tick();
    end
  endtask

  task automatic test_reset();
    in      = 8'h00;
    validin = 1'b0;
    apply_reset(3);
    checks++;
    if (out !== 1'b0) begin errors++; $display("FAIL reset out: got %b want 0", out); end
    checks++;
    if (load !== 1'b0) begin errors++; $display("FAIL reset load: got %b want 0", load); end
    checks++;
    if (active !== 1'b0) begin errors++; $display("FAIL reset active: got %b want 0", active); end
  endtask

  task automatic test_init_and_data();
    run_init("init", 8'hA5, 1'b1);
    expect_byte("a5", 8'hA5, 8'h3C, 1'b1);
    expect_byte("3c", 8'h3C, 8'h00, 1'b0);
    expect_byte("fill", c_COM, 8'h00, 1'b0);
    expect_byte("fill2", c_COM, 8'h00, 1'b0);
  endtask

  task automatic test_held_valid_and_back_to_back();
    reset   = 1'b1;
    in      = 8'hFF;
    validin = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    run_init("heldff", 8'hFF, 1'b1);
    expect_byte("ff", 8'hFF, 8'h00, 1'b1);
    expect_byte("b2b00", 8'h00, 8'hFF, 1'b1);
    expect_byte("b2bff", 8'hFF, 8'h00, 1'b0);
  endtask

  task automatic test_reset_mid_byte();
    apply_reset(3);
    run_init("pre", 8'hA5, 1'b1);
    tick(); tick(); tick();
    // Now in cycle 43 (cnt=3) of a byte carrying A5.
    apply_reset(1);
    checks++;
    if (out !== 1'b0) begin errors++; $display("FAIL midreset out: got %b want 0", out); end
    checks++;
    if (load !== 1'b0) begin errors++; $display("FAIL midreset load: got %b want 0", load); end
    checks++;
    if (active !== 1'b0) begin errors++; $display("FAIL midreset active: got %b want 0", active); end
    in      = 8'h00;
    validin = 1'b0;
    run_init("post", 8'h5A, 1'b1);
    expect_byte("5a", 8'h5A, 8'h00, 1'b0);
  endtask

  initial begin
    reset   = 1'b1;
    in      = 8'h00;
    validin = 1'b0;
    @(negedge clk32f);
    test_reset();
    test_init_and_data();
    test_held_valid_and_back_to_back();
    test_reset_mid_byte();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/par2ser_com.md
PAR2SER_COM -- requirements
Module: par2ser_com

Interface
REQ-001 SHALL have parameter COM, default 8'hBC: K28.5 symbol sent during initialization and in place of invalid bytes.
REQ-002 SHALL have parameter INIT_COM, default 4: COM symbols sent after reset before data is accepted (legal 1..15).
REQ-003 SHALL have port clk32f  input  1: bit clock at 8x the byte rate; sole clock, rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port in  input  8: byte from the 4x1 lane-combining stage.
REQ-006 SHALL have port validin  input  1: qualifies in.
REQ-007 SHALL have port out  output  1: serial bit stream, MSB first.
REQ-008 SHALL have port load  output  1: one-cycle strobe; in/validin are captured on the rising edge that ends this cycle.
REQ-009 SHALL have port active  output  1: high once the initial COM sequence is complete.

Function
REQ-010 SHALL keep a 3-bit bit counter cnt: cleared by reset, incremented every cycle, wrapping 7->0 with no stall.
REQ-011 SHALL keep an 8-bit shift register shreg; out SHALL be shreg[7] (registered, no combinational path from in).
REQ-012 SHALL shift shreg left by one bit (zero fill) on every edge where cnt != 7.
REQ-013 SHALL parallel-load shreg on every edge where cnt == 7, so byte period is exactly 8 cycles with no gap.
REQ-014 SHALL implement a 2-state FSM: INIT (after reset) and RUN.
REQ-015 In INIT, the cnt==7 load SHALL take COM regardless of validin/in, and a 4-bit com_cnt SHALL increment.
REQ-016 When the INIT_COM-th COM is loaded, the FSM SHALL move to RUN on that same edge and active SHALL be 1 from the next cycle.
REQ-017 In RUN, the cnt==7 load SHALL take in if validin=1, otherwise COM.
REQ-018 load SHALL equal (cnt==7) AND (state==RUN); load SHALL be 0 throughout INIT.
REQ-019 Latency: the byte captured at a load edge SHALL appear as out bit7 in the next cycle, then bit6..bit0 in the following 7 cycles.
REQ-020 active SHALL stay 1 in RUN until reset; validin low SHALL NOT drop active.
REQ-021 in/validin SHALL be ignored on all cycles except RUN load edges.

Reset
REQ-022 When reset=1 at a rising edge: cnt=0, shreg=8'h00, com_cnt=0, state=INIT. Next cycle out=0, load=0, active=0.
REQ-023 Reset mid-byte SHALL abort the byte in progress; no partial byte resumes after release.
REQ-024 After release, the first cycle SHALL have cnt=0, and the full INIT sequence SHALL repeat.

Verification
(Cycle 0 = first cycle after reset release, default parameters.)
REQ-025 Reset 3 cycles, validin=0 -> out=0 in cycles 0-7; 10111100 repeated from cycle 8; active=1 from cycle 32; first load=1 in cycle 39.
REQ-026 in=8'hA5, validin=1 at cycle 39 -> out cycles 40-47 = 1,0,1,0,0,1,0,1; next load in cycle 47.
REQ-027 Valid 8'h3C, then validin=0 -> 00111100 then 10111100, no gap; active stays 1.
REQ-028 validin=1, in=8'hFF held from cycle 0 -> only COM on out until cycle 39; load=0 in cycles 0-38; first 8'hFF bits appear in cycles 40-47.
REQ-029 Valid 8'h00 then 8'hFF back to back -> 8 zeros then 8 ones; load period exactly 8 cycles.
REQ-030 Reset asserted during RUN at cnt=3 -> next cycle out=0, load=0, active=0; after release the sequence matches REQ-025 exactly.
